// File: rtl/computie_bus_pkg.sv
// Shared Computie bus definitions: strobe/direction polarities, status codes,
// request/response record layout and the FSM state type used by the initiator.
package computie_bus_pkg;

   localparam logic ACTIVE       = 1'b0;
   localparam logic INACTIVE     = 1'b1;
   localparam logic DIR_TO_BUS   = 1'b1;
   localparam logic DIR_FROM_BUS = 1'b0;

   localparam logic [1:0] STATUS_OK      = 2'b00;
   localparam logic [1:0] STATUS_BERR    = 2'b01;
   localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

   localparam int unsigned MOD_READ_BIT = 0;
   localparam int unsigned MOD_RSVD_BIT = 1;
   localparam int unsigned MOD_W        = 2;
   localparam int unsigned STATUS_W     = 2;

   // Request record {mod, address, data}; response record {status, read_data}.
   function automatic int unsigned req_width(input int unsigned bw);
      return 2 * bw + MOD_W;
   endfunction

   function automatic int unsigned resp_width(input int unsigned bw);
      return bw + STATUS_W;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WAIT_ACK,
      ST_END,
      ST_RESP
   } state_t;

endpackage

// File: rtl/computie_bus_initiator.sv
// Computie bus initiator: runs one multiplexed address/data cycle per request
// record and returns {status, read_data}. All outputs are registered.
module computie_bus_initiator
   import computie_bus_pkg::*;
#(
   parameter int unsigned BITWIDTH = 32,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                            cb_clk,
   input  logic                            cb_reset,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [req_width(BITWIDTH)-1:0]  req_in,
   output logic                            resp_valid,
   input  logic                            resp_ready,
   output logic [resp_width(BITWIDTH)-1:0] resp_out,
   output logic                            cb_addr_strobe,
   output logic                            cb_data_strobe,
   output logic                            cb_read_write,
   output logic [BITWIDTH-1:0]             cb_addr_data_out,
   input  logic [BITWIDTH-1:0]             cb_addr_data_in,
   input  logic                            cb_data_ack,
   input  logic                            cb_bus_error,
   output logic                            send_receive,
   output logic                            addr_oe,
   output logic                            data_oe,
   output logic                            data_dir
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
   localparam int unsigned ADDR_LSB = BITWIDTH;
   localparam int unsigned MOD_LSB  = 2 * BITWIDTH;

   state_t                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [BITWIDTH-1:0]             data_q, data_d;
   logic                            req_ready_q, req_ready_d;
   logic                            resp_valid_q, resp_valid_d;
   logic [resp_width(BITWIDTH)-1:0] resp_q, resp_d;
   logic                            as_q, as_d;
   logic                            ds_q, ds_d;
   logic                            rw_q, rw_d;
   logic [BITWIDTH-1:0]             bus_q, bus_d;
   logic                            sr_q, sr_d;
   logic                            aoe_q, aoe_d;
   logic                            doe_q, doe_d;
   logic                            dir_q, dir_d;
   logic [BITWIDTH-1:0]             rd_sel;
   logic                            unused_mod;

   assign unused_mod = req_in[MOD_LSB + MOD_RSVD_BIT];
   assign rd_sel     = rw_q ? cb_addr_data_in : {BITWIDTH{1'b0}};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_d       = resp_q;
      as_d         = as_q;
      ds_d         = ds_q;
      rw_d         = rw_q;
      bus_d        = bus_q;
      sr_d         = sr_q;
      aoe_d        = aoe_q;
      doe_d        = doe_q;
      dir_d        = dir_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               data_d      = req_in[BITWIDTH-1:0];
               bus_d       = req_in[ADDR_LSB +: BITWIDTH];
               rw_d        = req_in[MOD_LSB + MOD_READ_BIT];
               sr_d        = 1'b1;
               dir_d       = DIR_TO_BUS;
               aoe_d       = ACTIVE;
               as_d        = ACTIVE;
               state_d     = ST_ADDR;
            end
         end

         // Outputs for each bus phase are loaded on the edge that enters it.
         ST_ADDR: begin
            aoe_d = INACTIVE;
            doe_d = ACTIVE;
            ds_d  = ACTIVE;
            if (rw_q) begin
               sr_d  = 1'b0;
               dir_d = DIR_FROM_BUS;
            end else begin
               bus_d = data_q;
               sr_d  = 1'b1;
               dir_d = DIR_TO_BUS;
            end
            state_d = ST_DATA;
         end

         ST_DATA: begin
            cnt_d   = '0;
            state_d = ST_WAIT_ACK;
         end

         ST_WAIT_ACK: begin
            if (!cb_bus_error) begin
               resp_d  = {STATUS_BERR, {BITWIDTH{1'b0}}};
               state_d = ST_END;
            end else if (!cb_data_ack) begin
               resp_d  = {STATUS_OK, rd_sel};
               state_d = ST_END;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               resp_d  = {STATUS_TIMEOUT, {BITWIDTH{1'b0}}};
               state_d = ST_END;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (state_d == ST_END) begin
               as_d  = INACTIVE;
               ds_d  = INACTIVE;
               aoe_d = INACTIVE;
               doe_d = INACTIVE;
               sr_d  = 1'b0;
               dir_d = DIR_FROM_BUS;
            end
         end

         ST_END: begin
            if (cb_data_ack && cb_bus_error) begin
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cb_clk) begin
      if (cb_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         data_q       <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= '0;
         as_q         <= INACTIVE;
         ds_q         <= INACTIVE;
         rw_q         <= 1'b1;
         bus_q        <= '0;
         sr_q         <= 1'b0;
         aoe_q        <= INACTIVE;
         doe_q        <= INACTIVE;
         dir_q        <= DIR_FROM_BUS;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_q       <= resp_d;
         as_q         <= as_d;
         ds_q         <= ds_d;
         rw_q         <= rw_d;
         bus_q        <= bus_d;
         sr_q         <= sr_d;
         aoe_q        <= aoe_d;
         doe_q        <= doe_d;
         dir_q        <= dir_d;
      end
   end

   assign req_ready        = req_ready_q;
   assign resp_valid       = resp_valid_q;
   assign resp_out         = resp_q;
   assign cb_addr_strobe   = as_q;
   assign cb_data_strobe   = ds_q;
   assign cb_read_write    = rw_q;
   assign cb_addr_data_out = bus_q;
   assign send_receive     = sr_q;
   assign addr_oe          = aoe_q;
   assign data_oe          = doe_q;
   assign data_dir         = dir_q;

endmodule

// File: tb/tb_computie_bus_initiator.sv
// Bench for computie_bus_initiator: acts as bus target and command source,
// predicting each response from the acknowledge timing it chooses.
module tb_computie_bus_initiator;

   localparam int unsigned BW = 32;
   localparam int unsigned TO = 8;

   localparam int M_ACK  = 0;
   localparam int M_BERR = 1;
   localparam int M_BOTH = 2;
   localparam int M_NONE = 3;

   logic            cb_clk = 1'b0;
   logic            cb_reset = 1'b1;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [2*BW+1:0] req_in = '0;
   logic            resp_valid;
   logic            resp_ready = 1'b0;
   logic [BW+1:0]   resp_out;
   logic            cb_addr_strobe, cb_data_strobe, cb_read_write;
   logic [BW-1:0]   cb_addr_data_out;
   logic [BW-1:0]   cb_addr_data_in = '0;
   logic            cb_data_ack = 1'b1;
   logic            cb_bus_error = 1'b1;
   logic            send_receive, addr_oe, data_oe, data_dir;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   computie_bus_initiator #(.BITWIDTH(BW), .TIMEOUT(TO)) dut (
      .cb_clk           (cb_clk),
      .cb_reset         (cb_reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_in           (req_in),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_out         (resp_out),
      .cb_addr_strobe   (cb_addr_strobe),
      .cb_data_strobe   (cb_data_strobe),
      .cb_read_write    (cb_read_write),
      .cb_addr_data_out (cb_addr_data_out),
      .cb_addr_data_in  (cb_addr_data_in),
      .cb_data_ack      (cb_data_ack),
      .cb_bus_error     (cb_bus_error),
      .send_receive     (send_receive),
      .addr_oe          (addr_oe),
      .data_oe          (data_oe),
      .data_dir         (data_dir)
   );

   always #5 cb_clk = ~cb_clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [38:0] bus_vec();
      return {cb_addr_strobe, cb_data_strobe, addr_oe, data_oe, send_receive,
              data_dir, cb_read_write, cb_addr_data_out};
   endfunction

   function automatic logic [74:0] reset_vec();
      return {cb_addr_strobe, cb_data_strobe, addr_oe, data_oe, send_receive,
              data_dir, cb_read_write, req_ready, resp_valid, resp_out, cb_addr_data_out};
   endfunction

   // Target answers within the window iff it asserts no later than TIMEOUT
   // cycles after the data strobe is first seen low.
   function automatic logic [BW+1:0] predict(input int mode, input int unsigned n,
                                            input logic is_read, input logic [BW-1:0] rd);
      if (mode == M_NONE || n > TO) return {2'b10, {BW{1'b0}}};
      if (mode != M_ACK)            return {2'b01, {BW{1'b0}}};
      return {2'b00, is_read ? rd : {BW{1'b0}}};
   endfunction

   task automatic wait_req_ready();
      int unsigned t = 0;
      while (!req_ready && t < 50) begin
         @(negedge cb_clk);
         t++;
      end
      check("req_ready", req_ready, 1'b1);
   endtask

   task automatic run_txn(input logic [1:0] mod, input logic [BW-1:0] addr,
                          input logic [BW-1:0] data, input logic [BW-1:0] rd,
                          input int mode, input int unsigned n,
                          input int unsigned h, input int unsigned bp);
      logic [BW+1:0] exp;
      logic [38:0]   obs;
      logic          is_read, responded;
      int unsigned   k, t, rel_exp;
      is_read   = mod[0];
      exp       = predict(mode, n, is_read, rd);
      responded = (mode != M_NONE) && (n <= TO);
      rel_exp   = responded ? (((n < 1) ? 1 : n) + 1) : (TO + 1);

      @(negedge cb_clk);
      req_in          = {mod, addr, data};
      req_valid       = 1'b1;
      cb_addr_data_in = $urandom;
      wait_req_ready();
      @(negedge cb_clk);
      req_valid = 1'b0;
      check("addr_phase", bus_vec(), {7'b0101110 | {6'b0, is_read}, addr});
      check("req_ready_busy", req_ready, 1'b0);

      @(negedge cb_clk);
      obs = bus_vec();
      if (is_read) obs[BW-1:0] = '0;
      check("data_phase", obs, is_read ? {7'b0010001, {BW{1'b0}}} : {7'b0010110, data});

      k = 0;
      while (k < 40) begin
         if (cb_data_strobe) break;
         if (k == n && mode != M_NONE) begin
            cb_addr_data_in = rd;
            if (mode == M_ACK || mode == M_BOTH)  cb_data_ack  = 1'b0;
            if (mode == M_BERR || mode == M_BOTH) cb_bus_error = 1'b0;
         end
         @(negedge cb_clk);
         k++;
      end
      check("release_cycle", k, rel_exp);
      check("release_state", {cb_addr_strobe, cb_data_strobe, addr_oe, data_oe,
                              send_receive, data_dir}, 6'b111100);
      if (!cb_data_ack || !cb_bus_error) begin
         repeat (h) @(negedge cb_clk);
         if (h > 0) check("end_holds", resp_valid, 1'b0);
      end
      cb_data_ack  = 1'b1;
      cb_bus_error = 1'b1;

      t = 0;
      while (!resp_valid && t < 20) begin
         @(negedge cb_clk);
         t++;
      end
      check("resp", {resp_valid, resp_out}, {1'b1, exp});
      repeat (bp) begin
         @(negedge cb_clk);
         check("resp_hold", {resp_valid, req_ready, resp_out}, {2'b10, exp});
      end
      resp_ready = 1'b1;
      @(negedge cb_clk);
      resp_ready = 1'b0;
      check("resp_done", {resp_valid, req_ready}, 2'b00);
      @(negedge cb_clk);
      check("turnaround", req_ready, 1'b1);
   endtask

   localparam logic [74:0] RESET_EXP = {7'b1111001, 2'b00, 66'b0};

   initial begin
      // Power-on reset, three cycles.
      @(negedge cb_clk);
      check("reset_state", reset_vec(), RESET_EXP);
      repeat (2) @(negedge cb_clk);
      cb_reset = 1'b0;
      @(negedge cb_clk);
      check("ready_after_reset", req_ready, 1'b1);

      run_txn(2'b00, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0,         M_ACK,  4,      0, 0);
      run_txn(2'b01, 32'h0000_2004, $urandom,      32'h1234_5678, M_ACK,  2,      1, 0);
      run_txn(2'b01, 32'h0000_3000, 32'h0,         32'hAAAA_5555, M_NONE, 0,      0, 0);
      run_txn(2'b01, 32'h0000_4000, 32'h0,         32'h0000_5555, M_BOTH, 3,      0, 0);
      run_txn(2'b01, 32'h0000_5000, 32'h0,         32'hCAFE_F00D, M_ACK,  TO,     0, 5);
      run_txn(2'b11, 32'h0000_6000, 32'h0,         32'h1111_2222, M_ACK,  TO + 1, 0, 5);
      run_txn(2'b00, 32'h0000_7000, 32'h7777_7777, 32'h3333_4444, M_BERR, 0,      2, 1);

      // Reset during the data phase discards the transaction.
      @(negedge cb_clk);
      req_in    = {2'b00, 32'h0000_8000, 32'h8888_8888};
      req_valid = 1'b1;
      wait_req_ready();
      @(negedge cb_clk);
      req_valid = 1'b0;
      @(negedge cb_clk);
      cb_reset = 1'b1;
      @(negedge cb_clk);
      check("mid_reset_state", reset_vec(), RESET_EXP);
      repeat (2) @(negedge cb_clk);
      cb_reset = 1'b0;
      @(negedge cb_clk);
      check("mid_reset_ready", {req_ready, resp_valid}, 2'b10);

      for (int i = 0; i < 40; i++) begin
         run_txn(2'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                 $urandom_range(0, TO + 3), $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
